// File: rtl/rom_uart_sender_pkg.sv
// Shared types and constants for the ROM-to-UART message sender.
// Holds the FSM state encoding, the bit-period calculation and the terminator byte.
package rom_uart_sender_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CHECK,
        SEND,
        FIN
    } state_t;

    localparam logic [7:0] TERM_BYTE = 8'h00;

    // Bit period in clock cycles, integer-truncated.
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/rom_uart_sender_tx_core.sv
// 8N1 UART transmitter: one byte per load, every bit exactly DIV cycles.
// tx_done is high during the last cycle of the stop bit.
module uart_tx_core #(
    parameter int DIV = 208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       txd,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CNT_W = $clog2(DIV + 1);

    logic [CNT_W-1:0] baud_cnt_reg;
    logic [3:0]       bit_idx_reg;
    logic [8:0]       shift_reg;
    logic             txd_reg;
    logic             tx_busy_reg;
    logic             bit_end;

    assign bit_end = (baud_cnt_reg == CNT_W'(DIV - 1));
    assign tx_done = tx_busy_reg && bit_end && (bit_idx_reg == 4'd9);
    assign txd     = txd_reg;
    assign tx_busy = tx_busy_reg;

    // shift_reg holds the data bits still to send, with the stop bit behind them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '1;
            txd_reg      <= 1'b1;
            tx_busy_reg  <= 1'b0;
        end else if (load) begin
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= {1'b1, data};
            txd_reg      <= 1'b0;
            tx_busy_reg  <= 1'b1;
        end else if (tx_busy_reg) begin
            if (bit_end) begin
                baud_cnt_reg <= '0;
                if (bit_idx_reg == 4'd9) begin
                    tx_busy_reg <= 1'b0;
                    txd_reg     <= 1'b1;
                end else begin
                    bit_idx_reg <= bit_idx_reg + 4'd1;
                    txd_reg     <= shift_reg[0];
                    shift_reg   <= {1'b1, shift_reg[8:1]};
                end
            end else begin
                baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rom_uart_sender.sv
// Walks the message ROM from address 0 and sends each byte as an 8N1 frame,
// stopping at the first 0x00 byte or after the last ROM address.
module rom_uart_sender
    import rom_uart_sender_pkg::*;
#(
    parameter int CLK_HZ = 24_000_000,
    parameter int BAUD   = 115_200,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              txd,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   byte_cnt
);

    localparam int                DIV      = calc_div(CLK_HZ, BAUD);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W:0]   byte_cnt_reg;
    logic              load;
    logic              tx_busy;
    logic              tx_done;
    logic              send_end;
    logic              accept;

    assign accept   = (state_reg == IDLE) && start;
    // An idle core in SEND can only follow a reset glitch; treat it as a finished frame.
    assign send_end = (state_reg == SEND) && (tx_done || !tx_busy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        case (state_reg)
            IDLE:  if (start) state_next = FETCH;
            FETCH: state_next = CHECK;
            CHECK: begin
                if (rom_data == TERM_BYTE) begin
                    state_next = FIN;
                end else begin
                    load       = 1'b1;
                    state_next = SEND;
                end
            end
            SEND:  if (send_end) state_next = (addr_reg == ADDR_MAX) ? FIN : FETCH;
            FIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg     <= '0;
            byte_cnt_reg <= '0;
        end else if (accept) begin
            addr_reg     <= '0;
            byte_cnt_reg <= '0;
        end else if (send_end) begin
            byte_cnt_reg <= byte_cnt_reg + CNT_ONE;
            if (addr_reg != ADDR_MAX) addr_reg <= addr_reg + ADDR_ONE;
        end
    end

    assign rom_addr = addr_reg;
    assign byte_cnt = byte_cnt_reg;
    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == FIN);

    uart_tx_core #(
        .DIV(DIV)
    ) u_tx (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .data   (rom_data),
        .txd    (txd),
        .tx_busy(tx_busy),
        .tx_done(tx_done)
    );

endmodule

// File: tb/tb_rom_uart_sender.sv
// Scenario bench for rom_uart_sender with DIV=10 and a 1-cycle-latency ROM.
// Expected line waveforms are rebuilt from the message contents and frame timing.
module tb_rom_uart_sender;

    localparam int CLK_HZ = 10;
    localparam int BAUD   = 1;
    localparam int ADDR_W = 6;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int FP     = 10 * DIV + 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              txd;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   byte_cnt;

    logic [7:0] rom [DEPTH];
    int checks = 0;
    int errors = 0;

    rom_uart_sender #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .txd     (txd),
        .busy    (busy),
        .done    (done),
        .byte_cnt(byte_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic fill_rom(input int len);
        for (int i = 0; i < DEPTH; i++) rom[i] = 8'($urandom_range(1, 255));
        if (len < DEPTH) rom[len] = 8'h00;
    endtask

    // Pulses start, then checks txd/busy/done cycle by cycle through one message.
    // extra1/extra2: edge indices (0 = accepting edge) where start is pulsed again.
    task automatic run_msg(input string name, input int extra1, input int extra2);
        int       n_bytes, done_n, exp_addr, k, off;
        int       txd_err, busy_err, done_err, done_seen;
        bit       exp_t;
        bit [9:0] frame;
        n_bytes = 0;
        while (n_bytes < DEPTH && rom[n_bytes] != 8'h00) n_bytes++;
        done_n   = (n_bytes < DEPTH) ? 2 + n_bytes * FP : 2 + (DEPTH - 1) * FP + 10 * DIV;
        exp_addr = (n_bytes < DEPTH) ? n_bytes : DEPTH - 1;
        txd_err = 0; busy_err = 0; done_err = 0; done_seen = 0;
        start = 1'b1;
        @(posedge clk); #1;
        for (int n = 0; n <= done_n + 1; n++) begin
            exp_t = 1'b1;
            if (n >= 2) begin
                k   = (n - 2) / FP;
                off = (n - 2) % FP;
                if (k < n_bytes && off < 10 * DIV) begin
                    frame = {1'b1, rom[k], 1'b0};
                    exp_t = frame[off / DIV];
                end
            end
            if (txd !== exp_t) txd_err++;
            if (busy !== (n <= done_n)) busy_err++;
            if (done !== (n == done_n)) done_err++;
            if (done === 1'b1) done_seen++;
            start = (n + 1 == extra1) || (n + 1 == extra2);
            if (n != done_n + 1) begin
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        checks++; if (txd_err != 0) begin errors++;
            $display("FAIL %s txd_wave: %0d bad cycles, required 0", name, txd_err); end
        checks++; if (busy_err != 0) begin errors++;
            $display("FAIL %s busy_wave: %0d bad cycles, required 0", name, busy_err); end
        checks++; if (done_err != 0) begin errors++;
            $display("FAIL %s done_wave: %0d bad cycles, required 0", name, done_err); end
        checks++; if (done_seen != 1) begin errors++;
            $display("FAIL %s done_count: got %0d, required 1", name, done_seen); end
        checks++; if (byte_cnt !== (ADDR_W+1)'(n_bytes)) begin errors++;
            $display("FAIL %s byte_cnt: got %0d, required %0d", name, byte_cnt, n_bytes); end
        checks++; if (rom_addr !== ADDR_W'(exp_addr)) begin errors++;
            $display("FAIL %s rom_addr: got %0d, required %0d", name, rom_addr, exp_addr); end
        $display("msg %s: bytes=%0d done_edge=%0d byte_cnt=%0d", name, n_bytes, done_n, byte_cnt);
    endtask

    task automatic idle_check(input string name, input int cycles);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s idle: %0d non-idle cycles, required 0", name, bad);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({txd, busy, done, rom_addr, byte_cnt} !== {1'b1, 1'b0, 1'b0, {ADDR_W{1'b0}}, {(ADDR_W+1){1'b0}}}) begin
            errors++;
            $display("FAIL reset_state: txd=%b busy=%b done=%b addr=%0d cnt=%0d, required 1 0 0 0 0",
                     txd, busy, done, rom_addr, byte_cnt);
        end
        rst_n = 1'b1;
        idle_check("post_reset", 5);
    endtask

    task automatic test_basic();
        fill_rom(2);
        rom[0] = 8'h48;
        rom[1] = 8'h49;
        run_msg("basic", -1, -1);
        idle_check("basic", 4);
    endtask

    task automatic test_empty();
        fill_rom(0);
        run_msg("empty", -1, -1);
        idle_check("empty", 4);
    endtask

    task automatic test_no_terminator();
        fill_rom(DEPTH);
        run_msg("no_term", -1, -1);
        idle_check("no_term", 4);
    endtask

    task automatic test_start_while_busy();
        int len;
        len = 2;
        fill_rom(len);
        // mid-frame of byte 0, and the edge at which FIN is the current state
        run_msg("start_busy", 2 + 5 * DIV + 3, 2 + len * FP + 1);
        idle_check("start_busy", 20);
    endtask

    task automatic test_reset_mid_frame();
        int       at;
        bit [7:0] b;
        fill_rom(3);
        b  = rom[0];
        at = 2 + 4 * DIV + 3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < at; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (txd !== b[3]) begin
            errors++;
            $display("FAIL rst_mid data_bit3: txd=%b, required %b", txd, b[3]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || byte_cnt !== '0) begin
            errors++;
            $display("FAIL rst_mid async: txd=%b busy=%b done=%b cnt=%0d, required 1 0 0 0",
                     txd, busy, done, byte_cnt);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        $display("msg rst_mid: reset asserted during data bit 3");
        idle_check("rst_mid", 30);
        run_msg("rst_mid_resend", -1, -1);
    endtask

    task automatic test_back_to_back();
        fill_rom(1 + int'($urandom_range(0, 2)));
        run_msg("b2b_first", -1, -1);
        run_msg("b2b_second", -1, -1);
        idle_check("b2b", 4);
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            fill_rom(int'($urandom_range(1, 6)));
            run_msg($sformatf("rand%0d", r), -1, -1);
            idle_check("rand", int'($urandom_range(1, 5)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_no_terminator();
        test_start_while_busy();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
